// File: rtl/uart_pkt_buffer_pkg.sv
// rtl/uart_pkt_buffer_pkg.sv - shared widths, FSM encoding and helpers for the packet buffer
package uart_pkt_buffer_pkg;

  localparam int PKT_DATA_W = 128;
  localparam int DROP_CNT_W = 16;

  // Transmit sequencer states; binary encoding keeps the state register at 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } pkt_state_e;

  // Saturating increment used by the overflow counter so it parks at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_pkt_buffer_if.sv
// rtl/uart_pkt_buffer_if.sv - receive/transmit handshake and status bundle for the packet buffer
interface uart_pkt_buffer_if
  import uart_pkt_buffer_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int DEPTH  = 4
);

  logic                    recv_done;
  logic [DATA_W-1:0]       recv_data;
  logic                    tx_busy;
  logic                    send_en;
  logic [DATA_W-1:0]       send_data;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [DROP_CNT_W-1:0]   drop_cnt;

  // The buffer itself sits on the slave side.
  modport slave (
    input  recv_done, recv_data, tx_busy,
    output send_en, send_data, fifo_count, drop_cnt
  );

  // Receiver/transmitter side (or a bench standing in for them).
  modport master (
    output recv_done, recv_data, tx_busy,
    input  send_en, send_data, fifo_count, drop_cnt
  );

endinterface

// File: rtl/uart_pkt_buffer_pkt_fifo.sv
// rtl/uart_pkt_buffer_pkt_fifo.sv - register FIFO of packets; overflow policy set by UART_PKT_OVERWRITE_EN
module pkt_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_pop;
  logic              do_write;
  logic              adv_rd;

  // Decide what a push/pop pair does this cycle, including the full-queue policy.
  always_comb begin
    full     = (count == (PTR_W+1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop & ~empty;
    overflow = push & full & ~do_pop;
`ifdef UART_PKT_OVERWRITE_EN
    // Oldest entry is sacrificed: the write lands on the head slot and the head moves on.
    do_write = push;
    adv_rd   = do_pop | overflow;
`else
    // Newest packet is discarded; queued contents stay as they are.
    do_write = push & ~overflow;
    adv_rd   = do_pop;
`endif
  end

  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; count is kept separately from the wrapping pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)   rd_ptr <= rd_ptr + 1'b1;
      if (do_write & ~adv_rd)      count <= count + 1'b1;
      else if (adv_rd & ~do_write) count <= count - 1'b1;
    end
  end

  // Packet storage; contents are meaningless until counted in, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_pkt_buffer.sv
// rtl/uart_pkt_buffer.sv - queues received packets and replays them to the transmitter; UART_PKT_OVERWRITE_EN selects overflow policy
module uart_pkt_buffer
  import uart_pkt_buffer_pkg::*;
#(
  parameter int DATA_W       = PKT_DATA_W,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  uart_pkt_buffer_if.slave bus
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  logic                   recv_done_d;
  logic                   push;
  logic [DATA_W-1:0]      head_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_empty;
  logic                   overflow;
  pkt_state_e             state_q;
  pkt_state_e             state_d;
  logic [TMO_W-1:0]       tmo_q;
  logic                   launch;
  logic                   send_en_q;
  logic [DATA_W-1:0]      send_data_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;

  // A held recv_done level counts once: only its rising edge pushes.
  assign push = bus.recv_done & ~recv_done_d;

  // Remember last recv_done level for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) recv_done_d <= 1'b0;
    else            recv_done_d <= bus.recv_done;
  end

  pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_data (bus.recv_data),
    .pop       (launch),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  // Next-state logic: launch from IDLE, wait for busy to rise (with timeout), then for it to fall.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          launch  = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy)                             state_d = ST_WAIT_DONE;
        else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus the busy-wait timer, which only runs while staying in WAIT_BUSY.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT_BUSY && state_d == ST_WAIT_BUSY) tmo_q <= tmo_q + 1'b1;
      else                                                     tmo_q <= '0;
    end
  end

  // Registered launch pulse; send_data holds the popped packet until the next launch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      send_en_q   <= 1'b0;
      send_data_q <= '0;
    end else begin
      send_en_q <= launch;
      if (launch) send_data_q <= head_data;
    end
  end

  // Count packets lost to a full queue, parking at the maximum value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    drop_cnt_q <= '0;
    else if (overflow) drop_cnt_q <= sat_inc(drop_cnt_q);
  end

  assign bus.send_en    = send_en_q;
  assign bus.send_data  = send_data_q;
  assign bus.fifo_count = fifo_count;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_uart_pkt_buffer.sv
// tb/tb_uart_pkt_buffer.sv - scoreboard bench for uart_pkt_buffer
module tb_uart_pkt_buffer;
  import uart_pkt_buffer_pkg::*;

  localparam int DATA_W       = 128;
  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #10 sys_clk = ~sys_clk;

  uart_pkt_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_pkt_buffer #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int                n_cmp = 0;
  int                n_err = 0;
  int                sent_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;
  logic              prev_send_en = 1'b0;

  logic tx_force  = 1'b0;
  logic resp_busy = 1'b0;
  bit   resp_on   = 1'b0;
  int   resp_dly  = 2;
  int   resp_len  = 3;

  assign bus.tx_busy = tx_force | resp_busy;

  // Scoreboard: every launch must be a single-cycle pulse, issued while not busy, carrying the next expected packet.
  always @(negedge sys_clk) begin
    if (bus.send_en === 1'b1) begin
      n_cmp++;
      if (prev_send_en === 1'b1) begin
        n_err++;
        $display("FAIL send_en_width: send_en high two cycles running, required one");
      end
      n_cmp++;
      if (bus.tx_busy !== 1'b0) begin
        n_err++;
        $display("FAIL send_while_busy: tx_busy=%b at send_en, required 0", bus.tx_busy);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_send: send_data=%h with nothing expected", bus.send_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.send_data !== mon_exp) begin
          n_err++;
          $display("FAIL send_data: got %h required %h", bus.send_data, mon_exp);
        end
      end
      sent_cnt++;
    end
    prev_send_en = bus.send_en;
  end

  // Transmitter model: raise busy resp_dly cycles after a launch and hold it for resp_len cycles.
  always begin
    @(negedge sys_clk);
    if (resp_on && bus.send_en === 1'b1) begin
      repeat (resp_dly) @(posedge sys_clk);
      #1 resp_busy = 1'b1;
      repeat (resp_len) @(posedge sys_clk);
      #1 resp_busy = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input logic [DATA_W-1:0] d, input bit expect_send);
    @(posedge sys_clk); #1;
    bus.recv_done = 1'b1;
    bus.recv_data = d;
    if (expect_send) exp_q.push_back(d);
    @(posedge sys_clk); #1;
    bus.recv_done = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && bus.fifo_count == 0 && bus.tx_busy === 1'b0) done = 1'b1;
    end
    repeat (resp_dly + resp_len + 4) @(negedge sys_clk);
    n_cmp++;
    if (!done || bus.fifo_count !== '0) begin
      n_err++;
      $display("FAIL %s_drain: pending=%0d fifo_count=%0d, required 0/0", name, exp_q.size(), bus.fifo_count);
    end
  endtask

  task automatic test_reset();
    bus.recv_done = 1'b0;
    bus.recv_data = '0;
    tx_force      = 1'b0;
    sys_rst_n     = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (bus.send_en !== 1'b0 || bus.send_data !== '0 || bus.fifo_count !== '0 || bus.drop_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_values: send_en=%b send_data=%h fifo_count=%0d drop_cnt=%0d, required all 0",
               bus.send_en, bus.send_data, bus.fifo_count, bus.drop_cnt);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (bus.send_en !== 1'b0 || bus.fifo_count !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle: send_en=%b fifo_count=%0d, required 0/0", bus.send_en, bus.fifo_count);
    end
  endtask

  task automatic test_single();
    resp_on  = 1'b1;
    resp_dly = 2;
    resp_len = 3;
    @(posedge sys_clk); #1;
    bus.recv_done = 1'b1;
    bus.recv_data = 128'hA5;
    exp_q.push_back(128'hA5);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== '0 || bus.send_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_pre_edge: fifo_count=%0d send_en=%b, required 0/0", bus.fifo_count, bus.send_en);
    end
    @(posedge sys_clk); #1;
    bus.recv_done = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd1 || bus.send_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_pushed: fifo_count=%0d send_en=%b, required 1/0", bus.fifo_count, bus.send_en);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (bus.send_en !== 1'b1 || bus.send_data !== 128'hA5 || bus.fifo_count !== '0) begin
      n_err++;
      $display("FAIL single_launch: send_en=%b send_data=%h fifo_count=%0d, required 1/a5/0",
               bus.send_en, bus.send_data, bus.fifo_count);
    end
    wait_drain(50, "single");
  endtask

  task automatic test_busy_order();
    int s0;
    resp_on  = 1'b1;
    resp_dly = 2;
    resp_len = 100;
    s0 = sent_cnt;
    push_pkt(128'h1111_0001, 1'b1);
    for (int i = 0; i < 10 && sent_cnt == s0; i++) @(negedge sys_clk);
    push_pkt(128'h2222_0002, 1'b1);
    push_pkt(128'h3333_0003, 1'b1);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd2) begin
      n_err++;
      $display("FAIL busy_queued: fifo_count=%0d, required 2", bus.fifo_count);
    end
    push_pkt(128'h4444_0004, 1'b1);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd3 || sent_cnt != s0 + 1) begin
      n_err++;
      $display("FAIL busy_queued3: fifo_count=%0d sent=%0d, required 3/%0d", bus.fifo_count, sent_cnt - s0, 1);
    end
    wait_drain(1000, "busy_order");
    n_cmp++;
    if (sent_cnt != s0 + 4) begin
      n_err++;
      $display("FAIL busy_sent: sent=%0d, required 4", sent_cnt - s0);
    end
  endtask

  task automatic test_overflow();
    resp_on = 1'b0;
    @(posedge sys_clk); #1;
    tx_force = 1'b1;
    for (int i = 1; i <= 6; i++) push_pkt(DATA_W'(32'hC0DE_0000 + i), 1'b0);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd4 || bus.drop_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL overflow_counts: fifo_count=%0d drop_cnt=%0d, required 4/2", bus.fifo_count, bus.drop_cnt);
    end
`ifdef UART_PKT_OVERWRITE_EN
    for (int i = 3; i <= 6; i++) exp_q.push_back(DATA_W'(32'hC0DE_0000 + i));
`else
    for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(32'hC0DE_0000 + i));
`endif
    resp_on  = 1'b1;
    resp_dly = 2;
    resp_len = 3;
    @(posedge sys_clk); #1;
    tx_force = 1'b0;
    wait_drain(200, "overflow");
    n_cmp++;
    if (bus.drop_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL overflow_drop_hold: drop_cnt=%0d, required 2", bus.drop_cnt);
    end
  endtask

  task automatic test_level_hold();
    resp_on = 1'b0;
    @(posedge sys_clk); #1;
    tx_force      = 1'b1;
    bus.recv_done = 1'b1;
    bus.recv_data = 128'hBEEF;
    exp_q.push_back(128'hBEEF);
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL level_mid: fifo_count=%0d, required 1", bus.fifo_count);
    end
    repeat (5) @(posedge sys_clk);
    #1 bus.recv_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL level_end: fifo_count=%0d, required 1", bus.fifo_count);
    end
    resp_on = 1'b1;
    @(posedge sys_clk); #1;
    tx_force = 1'b0;
    wait_drain(100, "level");
  endtask

  task automatic test_timeout();
    int gap;
    bit seen;
    resp_on = 1'b0;
    @(posedge sys_clk); #1;
    tx_force = 1'b1;
    push_pkt(128'hDEAD_0001, 1'b1);
    push_pkt(128'hDEAD_0002, 1'b1);
    @(posedge sys_clk); #1;
    tx_force = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.send_en === 1'b1) seen = 1'b1;
    end
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge sys_clk);
      gap++;
      if (bus.send_en === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || gap != BUSY_TIMEOUT + 1) begin
      n_err++;
      $display("FAIL timeout_gap: relaunch after %0d cycles (seen=%b), required %0d", gap, seen, BUSY_TIMEOUT + 1);
    end
    repeat (BUSY_TIMEOUT + 5) @(negedge sys_clk);
    n_cmp++;
    if (bus.fifo_count !== '0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_empty: fifo_count=%0d pending=%0d, required 0/0", bus.fifo_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int  s0;
    bit  seen;
    resp_on = 1'b0;
    @(posedge sys_clk); #1;
    tx_force = 1'b1;
    push_pkt(128'hAAAA, 1'b1);
    push_pkt(128'hBBBB, 1'b1);
    push_pkt(128'hCCCC, 1'b1);
    @(posedge sys_clk); #1;
    tx_force = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.send_en === 1'b1) seen = 1'b1;
    end
    @(posedge sys_clk); #1;
    tx_force = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (!seen || bus.fifo_count !== 3'd2 || bus.send_data !== 128'hAAAA) begin
      n_err++;
      $display("FAIL mid_setup: launched=%b fifo_count=%0d send_data=%h, required 1/2/aaaa",
               seen, bus.fifo_count, bus.send_data);
    end
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bus.send_en !== 1'b0 || bus.send_data !== '0 || bus.fifo_count !== '0 || bus.drop_cnt !== '0) begin
      n_err++;
      $display("FAIL async_reset: send_en=%b send_data=%h fifo_count=%0d drop_cnt=%0d, required all 0",
               bus.send_en, bus.send_data, bus.fifo_count, bus.drop_cnt);
    end
    exp_q.delete();
    tx_force = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    s0 = sent_cnt;
    repeat (30) @(negedge sys_clk);
    n_cmp++;
    if (sent_cnt != s0 || bus.fifo_count !== '0) begin
      n_err++;
      $display("FAIL post_reset_quiet: sends=%0d fifo_count=%0d, required 0/0", sent_cnt - s0, bus.fifo_count);
    end
    resp_on = 1'b1;
    push_pkt(128'hF00D, 1'b1);
    wait_drain(50, "post_reset");
    n_cmp++;
    if (sent_cnt != s0 + 1) begin
      n_err++;
      $display("FAIL post_reset_send: sends=%0d, required 1", sent_cnt - s0);
    end
  endtask

  initial begin
    bus.recv_done = 1'b0;
    bus.recv_data = '0;
    test_reset();
    test_single();
    test_busy_order();
    test_overflow();
    test_level_hold();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
